// File: rtl/nested_mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4-input nested-mux datapath (a,b,d,e) with burst grants.
// Optional per-source grant counters are enabled by defining ARB_GRANT_CNT_EN.
module nested_mux_rr_arbiter #(
    parameter int DW        = 4,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    input  logic [DW-1:0] din_d,
    input  logic [DW-1:0] din_e,
    input  logic          dout_ready,
`ifdef ARB_GRANT_CNT_EN
    input  logic          cnt_clr,
    output logic [31:0]   grant_cnt,
`endif
    output logic [3:0]    gnt,
    output logic [3:0]    src_ack,
    output logic          sel1,
    output logic          sel2,
    output logic          sel3,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    // Handshake: a beat moves when dout_valid && dout_ready are both high in the same cycle;
    // dout_valid never waits on dout_ready, and dout holds steady while ready is low.

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;

    logic [1:0]    g_idx;
    logic          fire;
    logic          release_grant;
    logic [1:0]    arb_ptr;
    logic [1:0]    scan_idx;
    logic [1:0]    win_idx;
    logic          win_found;
    logic [DW-1:0] mux_out;

    always_comb begin
        g_idx = 2'd0;
        case (gnt_q)
            4'b0010: g_idx = 2'd1;
            4'b0100: g_idx = 2'd2;
            4'b1000: g_idx = 2'd3;
            default: g_idx = 2'd0;
        endcase
    end

    assign dout_valid    = (state_q == ST_XFER) && ((req & gnt_q) != 4'b0000);
    assign fire          = dout_valid && dout_ready;
    assign src_ack       = fire ? gnt_q : 4'b0000;
    // A granted source that is not requesting ends its grant without a beat.
    assign release_grant = (state_q == ST_XFER) && (!dout_valid || (fire && (beat_cnt_q == LAST_BEAT)));
    assign arb_ptr       = release_grant ? (g_idx + 2'd1) : rr_ptr_q;

    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        scan_idx  = arb_ptr;
        for (int i = 0; i < 4; i++) begin
            scan_idx = arb_ptr + 2'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_XFER;
                    gnt_d      = 4'b0001 << win_idx;
                    beat_cnt_d = 4'd0;
                end
            end
            ST_XFER: begin
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
                // Re-arbitrate in the releasing edge so back-to-back grants have no bubble.
                if (release_grant) begin
                    rr_ptr_d   = g_idx + 2'd1;
                    beat_cnt_d = 4'd0;
                    if (win_found) begin
                        gnt_d = 4'b0001 << win_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        sel_d = 3'b000;
        case (gnt_d)
            4'b0001: sel_d = 3'b100;
            4'b0010: sel_d = 3'b010;
            4'b0100: sel_d = 3'b001;
            default: sel_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= 3'b000;
            rr_ptr_q   <= 2'd0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Select 000 routes source e, so dout is forced to zero when nothing is granted.
    assign mux_out = sel_q[2] ? din_a : (sel_q[1] ? din_b : (sel_q[0] ? din_d : din_e));
    assign dout    = (gnt_q != 4'b0000) ? mux_out : '0;
    assign gnt     = gnt_q;
    assign sel1    = sel_q[2];
    assign sel2    = sel_q[1];
    assign sel3    = sel_q[0];

`ifdef ARB_GRANT_CNT_EN
    logic       grant_issue;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    assign grant_issue = (gnt_d != 4'b0000) && ((state_q == ST_IDLE) || release_grant);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = 8'd0;
            end else if (grant_issue && (win_idx == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
